product_accumulator: RTL and testbench

Sequential accumulator that sits directly downstream of the pipelined 8x8 multiplier and consumes its 16-bit unsigned `product` stream. It sums a programmed number of valid products into a saturating accumulator and presents the total with a valid/ack handshake. It turns the multiplier into a dot-product / MAC datapath without modifying the multiplier.

---
 rtl/product_accumulator.sv | 98 +++++++++
 tb/tb_product_accumulator.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Saturating accumulator for the 16-bit product stream of the pipelined multiplier.
// Sums a programmed number of valid products and presents the total with a valid/ack handshake.
module product_accumulator #(
    parameter int LEN_W = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             prod_valid,
    input  logic [15:0]      product,
    output logic             busy,
    output logic [ACC_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic             ovf, ovf_n;
    logic [ACC_W:0]   sum;
    logic             take_start;

    assign sum        = {1'b0, acc} + (ACC_W+1)'(product);
    // DONE with an ack behaves exactly like IDLE, so a new run can launch without a gap
    assign take_start = start && ((state == IDLE) || ((state == DONE) && result_ack));

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_n   = ovf;

        case (state)
            IDLE: ;
            ACCUM: begin
                if (prod_valid) begin
                    if (sum[ACC_W]) begin
                        acc_n = '1;
                        ovf_n = 1'b1;
                    end else begin
                        acc_n = sum[ACC_W-1:0];
                    end
                    cnt_n = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (take_start) begin
            acc_n = '0;
            ovf_n = 1'b0;
            if (len != '0) begin
                cnt_n   = len;
                state_n = ACCUM;
            end else begin
                state_n = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            ovf   <= ovf_n;
        end
    end

    assign busy         = (state == ACCUM);
    assign result_valid = (state == DONE);
    assign result       = acc;
    assign overflow     = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomised scoreboard bench for product_accumulator: the driver queues expected totals,
// and a negedge monitor checks each presented result against them.
module tb_product_accumulator;

    localparam int LEN_W = 8;
    localparam int ACC_W = 20;
    localparam longint MAXV = (64'd1 << ACC_W) - 1;

    typedef struct packed {
        logic [ACC_W-1:0] res;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             prod_valid = 1'b0;
    logic [15:0]      product = '0;
    logic             busy;
    logic [ACC_W-1:0] result;
    logic             result_valid;
    logic             result_ack = 1'b0;
    logic             overflow;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    exp_t        sb[$];
    int unsigned terms[$];
    exp_t        cur;
    bit          presented = 1'b0;

    product_accumulator #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .prod_valid(prod_valid), .product(product), .busy(busy),
        .result(result), .result_valid(result_valid),
        .result_ack(result_ack), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Saturation is monotonic, so clamping the exact total once is the same as clamping per term.
    task automatic push_expected();
        longint total = 0;
        exp_t   e;
        foreach (terms[i]) total += terms[i];
        if (total > MAXV) begin
            e.res = '1;
            e.ovf = 1'b1;
        end else begin
            e.res = ACC_W'(total);
            e.ovf = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic make_terms(input int n, input bit big);
        terms.delete();
        for (int i = 0; i < n; i++)
            terms.push_back(big ? $urandom_range(40000, 65535) : $urandom_range(0, 3000));
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            if (!presented) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    presented = 1'b1;
                end
            end
            if (presented) begin
                chk("result", result, cur.res);
                chk("overflow", overflow, cur.ovf);
            end
            if (result_ack) presented = 1'b0;
        end else begin
            presented = 1'b0;
        end
    end

    task automatic launch(input bit with_ack);
        push_expected();
        start      = 1'b1;
        result_ack = with_ack;
        len        = LEN_W'(terms.size());
        step();
        start      = 1'b0;
        result_ack = 1'b0;
        len        = LEN_W'($urandom);
        if (terms.size() > 0) begin
            chk("busy_after_start", busy, 1);
            chk("valid_after_start", result_valid, 0);
        end else begin
            chk("len0_valid", result_valid, 1);
            chk("len0_busy", busy, 0);
        end
    endtask

    task automatic feed(input int bubble_pct);
        foreach (terms[i]) begin
            while ($urandom_range(0, 99) < bubble_pct) begin
                prod_valid = 1'b0;
                product    = 16'($urandom);
                start      = 1'($urandom);
                step();
                chk("busy_in_bubble", busy, 1);
            end
            prod_valid = 1'b1;
            product    = 16'(terms[i]);
            start      = 1'($urandom);
            step();
        end
        prod_valid = 1'b0;
        start      = 1'b0;
        chk("busy_after_last", busy, 0);
        chk("valid_after_last", result_valid, 1);
    endtask

    task automatic hold_done(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            prod_valid = 1'($urandom);
            product    = 16'd999;
            start      = 1'($urandom);
            step();
            chk("valid_held", result_valid, 1);
        end
        prod_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic ack_and_idle(input int idle_cycles);
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk("valid_after_ack", result_valid, 0);
        for (int i = 0; i < idle_cycles; i++) begin
            prod_valid = 1'b1;
            product    = 16'd999;
            step();
            chk("idle_busy", busy, 0);
        end
        prod_valid = 1'b0;
    endtask

    task automatic run_terms(input int bubble_pct, input int hold);
        launch(1'b0);
        if (terms.size() > 0) feed(bubble_pct);
        hold_done(hold);
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        check_reset_outputs();
        ack_and_idle(3);

        terms = '{100, 200, 300, 400};
        run_terms(0, 2);
        ack_and_idle(1);

        terms = '{5, 7, 9};
        run_terms(60, 1);
        ack_and_idle(1);

        terms.delete();
        run_terms(0, 2);
        ack_and_idle(1);

        terms.delete();
        for (int i = 0; i < 17; i++) terms.push_back(65025);
        run_terms(0, 5);
        ack_and_idle(1);

        terms = '{3};
        run_terms(0, 1);

        terms = '{10, 20};
        launch(1'b1);
        feed(0);
        hold_done(2);

        terms.delete();
        launch(1'b1);
        hold_done(1);
        ack_and_idle(1);

        terms = '{1000, 2000, 3000, 4000, 5000};
        start = 1'b1;
        len   = LEN_W'(5);
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1;
            product    = 16'(terms[i]);
            step();
        end
        prod_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_outputs();
        step();
        check_reset_outputs();

        terms = '{42};
        run_terms(0, 1);

        for (int r = 0; r < 40; r++) begin
            make_terms($urandom_range(0, 20), 1'($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 2) == 0) begin
                launch(1'b1);
            end else begin
                ack_and_idle($urandom_range(0, 3));
                launch(1'b0);
            end
            if (terms.size() > 0) feed($urandom_range(0, 50));
            hold_done($urandom_range(0, 3));
        end
        ack_and_idle(2);

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
